// File: rtl/irq_coalescer_if.sv
// rtl/irq_coalescer_if.sv - event/config inputs and irq/pending outputs of the interrupt coalescer
interface irq_coalescer_if #(
    parameter int IRQ_COUNT = 4,
    parameter int CNT_WIDTH = 8,
    parameter int TMR_WIDTH = 16
);
    logic [IRQ_COUNT-1:0] event_in;
    logic [IRQ_COUNT-1:0] enable;
    logic [CNT_WIDTH-1:0] threshold;
    logic [TMR_WIDTH-1:0] timeout;
    logic                 flush;
    logic [IRQ_COUNT-1:0] irq_out;
    logic [IRQ_COUNT-1:0] pending;

    modport master (
        output event_in, enable, threshold, timeout, flush,
        input  irq_out, pending
    );

    modport slave (
        input  event_in, enable, threshold, timeout, flush,
        output irq_out, pending
    );
endinterface

// File: rtl/irq_coalescer.sv
// rtl/irq_coalescer.sv - per-source rising-edge batcher firing one pulse on count threshold, timeout or flush
module irq_coalescer #(
    parameter int IRQ_COUNT = 4,
    parameter int CNT_WIDTH = 8,
    parameter int TMR_WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    irq_coalescer_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    logic [IRQ_COUNT-1:0] event_q, event_d;
    logic [IRQ_COUNT-1:0] rise;
    logic [CNT_WIDTH-1:0] thr_eff;
    logic                 timeout_on;

    assign event_d    = bus.event_in;
    assign rise       = bus.event_in & ~event_q & bus.enable;
    assign thr_eff    = (bus.threshold == '0) ? CNT_WIDTH'(1) : bus.threshold;
    assign timeout_on = (bus.timeout != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_q <= '0;
        end else begin
            event_q <= event_d;
        end
    end

    for (genvar k = 0; k < IRQ_COUNT; k++) begin : g_src
        state_t               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
        logic [TMR_WIDTH-1:0] tmr_q, tmr_d, tmr_nxt;
        logic                 irq_q, irq_d;
        logic                 fire;

        assign cnt_nxt = (rise[k] && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        assign tmr_nxt = (tmr_q != '1) ? tmr_q + TMR_WIDTH'(1) : tmr_q;
        assign fire    = (cnt_nxt >= thr_eff)
                       || (timeout_on && (tmr_q >= bus.timeout))
                       || bus.flush;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tmr_d   = tmr_q;
            irq_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise[k]) begin
                        if (thr_eff <= CNT_WIDTH'(1)) begin
                            irq_d = 1'b1;
                        end else begin
                            cnt_d   = CNT_WIDTH'(1);
                            tmr_d   = TMR_WIDTH'(1);
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    // A disabled source drops its batch silently; a rise in the fire cycle joins the fired batch.
                    if (!bus.enable[k]) begin
                        cnt_d   = '0;
                        tmr_d   = '0;
                        state_d = IDLE;
                    end else if (fire) begin
                        irq_d   = 1'b1;
                        cnt_d   = '0;
                        tmr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_nxt;
                        tmr_d = tmr_nxt;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                tmr_q   <= '0;
                irq_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tmr_q   <= tmr_d;
                irq_q   <= irq_d;
            end
        end

        assign bus.irq_out[k] = irq_q;
        assign bus.pending[k] = (state_q == ACCUM);
    end
endmodule
